rom_fetch_ctrl: RTL
===================

ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, ROM word width.
REQ-002 Parameter ADDR_W, default 4, ROM address width (depth 2**ADDR_W).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first ROM address of burst, captured on accepted start.
REQ-007 length  input  ADDR_W+1  word count 0..16, captured on accepted start.
REQ-008 rom_addr  output  ADDR_W  address presented to ROM.
REQ-009 rom_cs  output  1  ROM chip select; ROM reads on its falling edge; idle high.
REQ-010 rom_data  input  DATA_W  ROM read data, valid from the cycle after rom_cs falls.
REQ-011 out_data / out_valid / out_ready  output/output/input  DATA_W/1/1  downstream stream; transfer when valid and ready are both high.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse at burst end.
REQ-014 err  output  1  one-cycle pulse when start is accepted with length 0.
REQ-015 checksum  output  DATA_W  running mod-2**DATA_W sum of words transferred in the current or last burst.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE, CAPTURE, PRESENT, DONE.
REQ-017 IDLE: start with length>0 SHALL capture base_addr/length, clear checksum, and go to SETUP; start with length 0 SHALL pulse err, stay in IDLE, and leave checksum unchanged.
REQ-018 SETUP: rom_addr SHALL equal the current address and rom_cs SHALL be high; go to STROBE.
REQ-019 STROBE: rom_cs SHALL be low for exactly one cycle with rom_addr held stable; go to CAPTURE.
REQ-020 CAPTURE: rom_cs SHALL return high, rom_data SHALL be registered into out_data; go to PRESENT.
REQ-021 PRESENT: out_valid SHALL be high and out_data SHALL be stable until out_ready is high.
REQ-022 On transfer, checksum SHALL add out_data, the remaining count SHALL decrement, and the address SHALL increment modulo 2**ADDR_W (15 wraps to 0); the FSM SHALL go to SETUP if words remain, otherwise to DONE.
REQ-023 Latency: out_valid SHALL rise 3 cycles after leaving IDLE or after the previous transfer; with out_ready held high, throughput SHALL be one word per 4 cycles.
REQ-024 DONE: done SHALL pulse for one cycle, busy SHALL drop in the same cycle, and the FSM SHALL return to IDLE.
REQ-025 start while busy SHALL be ignored; base_addr and length changes mid-burst SHALL have no effect.
REQ-026 out_valid SHALL be high only in PRESENT; rom_cs SHALL be low only in STROBE; err and done SHALL never be asserted together.
REQ-027 checksum SHALL hold its value after DONE until the next accepted non-zero start.

Reset
REQ-028 rst SHALL force the FSM to IDLE immediately, regardless of clk.
REQ-029 On reset: rom_cs=1, rom_addr=0, out_data=0, out_valid=0, busy=0, done=0, err=0, checksum=0.
REQ-030 Reset mid-burst SHALL abandon the burst with no done pulse; the first start after release SHALL begin a fresh burst.

Structure
REQ-031 A shared package SHALL hold DATA_W/ADDR_W defaults and the FSM state encoding.
REQ-032 The design SHALL be a single module with no sub-modules; the bench SHALL supply a behavioural ROM reading on the falling edge of cs.

Verification
REQ-033 Bench ROM contents: 0:501, 1:3401, 2:801, 3:121, 14:3601, 15:3401.
REQ-034 Scenario 1: base 0, length 3, out_ready=1 -> words 501, 3401, 801 appear 4 cycles apart; done pulses; checksum=4703.
REQ-035 Scenario 2: base 14, length 4 -> wrapped sequence 3601, 3401, 501, 3401; checksum=10904.
REQ-036 Scenario 3: base 1, length 2, out_ready low for 5 cycles on the first word -> out_valid and out_data=3401 held stable, rom_cs stays high, then 801 follows.
REQ-037 Scenario 4: start with length 0 -> err pulses one cycle; busy, rom_cs, and checksum unchanged.
REQ-038 Scenario 5: base 0, length 16, rst asserted during the third PRESENT -> all outputs reset immediately with no done pulse; a new start of base 3, length 1 returns 121.
REQ-039 Scenario 6: start re-pulsed mid-burst with different base/length -> the original burst completes unaltered.

Source files
------------

// File: rtl/rom_fetch_ctrl_pkg.sv
// rtl/rom_fetch_ctrl_pkg.sv - shared widths and FSM encoding for the ROM fetch controller
package rom_fetch_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// rtl/rom_fetch_ctrl_if.sv - ROM strobe bus plus downstream word stream
interface rom_fetch_ctrl_if
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cs;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rom_addr, rom_cs, out_data, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, rom_cs, out_data, out_valid,
    output rom_data, out_ready
  );

endinterface

// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - bursts words out of a falling-edge-strobed ROM onto a stream
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  rom_fetch_ctrl_if.master  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remain;
  logic [DATA_W-1:0] data_q;
  logic              accept, reject, xfer;
  logic              cs_c, valid_c, busy_c, done_c;

  assign accept = (state == ST_IDLE) && start && (length != '0);
  assign reject = (state == ST_IDLE) && start && (length == '0);
  assign xfer   = (state == ST_PRESENT) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_SETUP;
      ST_SETUP:   state_nxt = ST_STROBE;
      ST_STROBE:  state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_PRESENT;
      ST_PRESENT: if (xfer) state_nxt = (remain > CNT_ONE) ? ST_SETUP : ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_c    = 1'b1;
    valid_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      ST_SETUP:   busy_c = 1'b1;
      ST_STROBE:  begin busy_c = 1'b1; cs_c = 1'b0; end
      ST_CAPTURE: busy_c = 1'b1;
      ST_PRESENT: begin busy_c = 1'b1; valid_c = 1'b1; end
      ST_DONE:    done_c = 1'b1;
      default:    ;
    endcase
  end

  // The ROM latches on cs falling at STROBE entry, so data is settled by the end of CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      remain   <= '0;
      data_q   <= '0;
      checksum <= '0;
      err      <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        addr     <= base_addr;
        remain   <= length;
        checksum <= '0;
      end else if (xfer) begin
        addr     <= addr + ADDR_ONE;
        remain   <= remain - CNT_ONE;
        checksum <= checksum + data_q;
      end
      if (state == ST_CAPTURE) data_q <= bus.rom_data;
    end
  end

  assign bus.rom_addr  = addr;
  assign bus.rom_cs    = cs_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_c;
  assign busy          = busy_c;
  assign done          = done_c;

endmodule
